// File: rtl/tile_stream_ctrl.sv
// Tile sequencer: walks an image in raster order of tiles, reading each tile over
// Avalon-MM, handing it to the filter (unless bypassed), then writing it back.
module tile_stream_ctrl #(
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 480,
    parameter int unsigned TILE_W = 8,
    parameter int unsigned TILE_H = 6,
    parameter int unsigned BPP    = 4,
    parameter int unsigned ADDR_W = 32,
    localparam int unsigned NTX   = IMG_W / TILE_W,
    localparam int unsigned NTY   = IMG_H / TILE_H,
    localparam int unsigned TX_W  = (NTX > 1) ? $clog2(NTX) : 1,
    localparam int unsigned TY_W  = (NTY > 1) ? $clog2(NTY) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    input  logic              bypass,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    output logic              rd_push,
    output logic              wr_pop,
    output logic              filt_start,
    input  logic              filt_done,
    output logic [TX_W-1:0]   tile_x,
    output logic [TY_W-1:0]   tile_y,
    output logic              busy,
    output logic              done,
    output logic              aborted
);
    localparam int unsigned PX_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int unsigned PY_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, FILT_GO, FILT_WAIT, WR_REQ, NEXT, FIN
    } state_t;

    state_t            state, state_n;
    logic [PX_W-1:0]   px_x, px_x_n;
    logic [PY_W-1:0]   px_y, px_y_n;
    logic [TX_W-1:0]   tx_n;
    logic [TY_W-1:0]   ty_n;
    logic [ADDR_W-1:0] src_q, src_n, dst_q, dst_n, addr_n;
    logic              byp_q, byp_n, abort_q, abort_n, aborted_n;
    logic              adv_px, adv_tile, last_px, last_tile;

    // Byte address of a pixel; all arithmetic wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [TX_W-1:0]   tx,
                                                   input logic [TY_W-1:0]   ty,
                                                   input logic [PX_W-1:0]   px,
                                                   input logic [PY_W-1:0]   py);
        logic [ADDR_W-1:0] row, col;
        row = ADDR_W'(ty) * ADDR_W'(TILE_H) + ADDR_W'(py);
        col = ADDR_W'(tx) * ADDR_W'(TILE_W) + ADDR_W'(px);
        return base + (row * ADDR_W'(IMG_W) + col) * ADDR_W'(BPP);
    endfunction

    always_comb begin
        state_n   = state;
        px_x_n    = px_x;
        px_y_n    = px_y;
        tx_n      = tile_x;
        ty_n      = tile_y;
        src_n     = src_q;
        dst_n     = dst_q;
        byp_n     = byp_q;
        abort_n   = abort_q | (abort && (state != IDLE));
        aborted_n = aborted;
        rd_push   = 1'b0;
        wr_pop    = 1'b0;
        adv_px    = 1'b0;
        adv_tile  = 1'b0;
        addr_n    = avm_address;
        last_px   = (px_x == PX_W'(TILE_W - 1)) && (px_y == PY_W'(TILE_H - 1));
        last_tile = (tile_x == TX_W'(NTX - 1)) && (tile_y == TY_W'(NTY - 1));

        case (state)
            IDLE: if (start) begin
                state_n   = RD_REQ;
                px_x_n    = '0;
                px_y_n    = '0;
                tx_n      = '0;
                ty_n      = '0;
                src_n     = src_base;
                dst_n     = dst_base;
                byp_n     = bypass;
                abort_n   = 1'b0;
                aborted_n = 1'b0;
            end
            RD_REQ: if (!avm_waitrequest) state_n = RD_WAIT;
            RD_WAIT: if (avm_readdatavalid) begin
                rd_push = 1'b1;
                adv_px  = 1'b1;
                if (abort_n) begin
                    state_n   = FIN;
                    aborted_n = 1'b1;
                end else if (last_px) begin
                    state_n = byp_q ? WR_REQ : FILT_GO;
                end else begin
                    state_n = RD_REQ;
                end
            end
            FILT_GO: state_n = FILT_WAIT;
            FILT_WAIT: if (filt_done) begin
                px_x_n = '0;
                px_y_n = '0;
                if (abort_n) begin
                    state_n   = FIN;
                    aborted_n = 1'b1;
                end else begin
                    state_n = WR_REQ;
                end
            end
            WR_REQ: if (!avm_waitrequest) begin
                wr_pop = 1'b1;
                adv_px = 1'b1;
                if (abort_n) begin
                    state_n   = FIN;
                    aborted_n = 1'b1;
                end else if (last_px) begin
                    state_n = NEXT;
                end
            end
            NEXT: begin
                adv_tile = 1'b1;
                state_n  = last_tile ? FIN : RD_REQ;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Row-major pixel walk within the tile; wraps to 0,0 after the last pixel.
        if (adv_px) begin
            if (px_x == PX_W'(TILE_W - 1)) begin
                px_x_n = '0;
                px_y_n = (px_y == PY_W'(TILE_H - 1)) ? '0 : PY_W'(px_y + 1'b1);
            end else begin
                px_x_n = PX_W'(px_x + 1'b1);
            end
        end
        if (adv_tile) begin
            if (tile_x == TX_W'(NTX - 1)) begin
                tx_n = '0;
                ty_n = (tile_y == TY_W'(NTY - 1)) ? '0 : TY_W'(tile_y + 1'b1);
            end else begin
                tx_n = TX_W'(tile_x + 1'b1);
            end
        end

        // Address is loaded with the request it belongs to, so it is valid as read/write rises.
        if (state_n == RD_REQ)      addr_n = pix_addr(src_n, tx_n, ty_n, px_x_n, px_y_n);
        else if (state_n == WR_REQ) addr_n = pix_addr(dst_n, tx_n, ty_n, px_x_n, px_y_n);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            px_x        <= '0;
            px_y        <= '0;
            tile_x      <= '0;
            tile_y      <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            byp_q       <= 1'b0;
            abort_q     <= 1'b0;
            aborted     <= 1'b0;
            avm_address <= '0;
            avm_read    <= 1'b0;
            avm_write   <= 1'b0;
            filt_start  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            px_x        <= px_x_n;
            px_y        <= px_y_n;
            tile_x      <= tx_n;
            tile_y      <= ty_n;
            src_q       <= src_n;
            dst_q       <= dst_n;
            byp_q       <= byp_n;
            abort_q     <= abort_n;
            aborted     <= aborted_n;
            avm_address <= addr_n;
            avm_read    <= (state_n == RD_REQ);
            avm_write   <= (state_n == WR_REQ);
            filt_start  <= (state_n == FILT_GO);
            busy        <= (state_n != IDLE);
            done        <= (state_n == FIN);
        end
    end

endmodule

// File: tb/tb_tile_stream_ctrl.sv
// Randomised bench for tile_stream_ctrl on a 16x12 image of 8x6 tiles, with an
// Avalon slave / filter responder and a coordinate-based address model.
module tb_tile_stream_ctrl;
    localparam int IMG_W = 16;
    localparam int IMG_H = 12;
    localparam int TW    = 8;
    localparam int TH    = 6;
    localparam int BPP   = 4;
    localparam int NTX   = IMG_W / TW;
    localparam int NPX   = TW * TH;
    localparam int NPIX  = IMG_W * IMG_H;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0, abort = 1'b0, bypass = 1'b0;
    logic [31:0] src_base = '0, dst_base = '0;
    logic [31:0] avm_address;
    logic        avm_read, avm_write;
    logic        avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
    logic        rd_push, wr_pop, filt_start;
    logic        filt_done = 1'b0;
    logic [0:0]  tile_x, tile_y;
    logic        busy, done, aborted;

    tile_stream_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .TILE_W(TW), .TILE_H(TH),
                       .BPP(BPP), .ADDR_W(32)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .bypass(bypass),
        .src_base(src_base), .dst_base(dst_base), .avm_address(avm_address),
        .avm_read(avm_read), .avm_write(avm_write), .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid), .rd_push(rd_push), .wr_pop(wr_pop),
        .filt_start(filt_start), .filt_done(filt_done), .tile_x(tile_x), .tile_y(tile_y),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observations of the last frame
    logic [31:0] rd_q[$], wr_q[$];
    int          tq[$];
    int          n_push, n_pop, n_fs, n_done, done_cyc, last_push_cyc, last_wr_cyc;
    int          viol, xcnt, push_mis, pop_mis;
    bit          ab_at_done, busy_after, aborted_after, timed_out, rst_hit;
    logic [41:0] rst_vec;

    // Reference: pixel k of the frame in tile-major, row-major-within-tile order.
    function automatic logic [31:0] model_addr(input logic [31:0] base, input int k);
        int t, p, x, y;
        t = k / NPX;
        p = k % NPX;
        x = (t % NTX) * TW + p % TW;
        y = (t / NTX) * TH + p / TW;
        return base + 32'((y * IMG_W + x) * BPP);
    endfunction

    // Drives one frame as bus slave and filter, recording what the DUT does.
    task automatic run_frame(input bit byp, input int stall_pct, input int spur_pct,
                             input int abort_rd, input int rst_wr, input int fdelay,
                             input logic [31:0] sb, input logic [31:0] db);
        bit          rdv_pend, rdv_next, prev_stall, fin;
        logic [33:0] prev_req;
        int          fcnt, hold;
        rd_q.delete(); wr_q.delete(); tq.delete();
        n_push = 0; n_pop = 0; n_fs = 0; n_done = 0; done_cyc = -1; last_push_cyc = -1;
        last_wr_cyc = -1; viol = 0; xcnt = 0; push_mis = 0; pop_mis = 0;
        ab_at_done = 0; busy_after = 1; aborted_after = 0; rst_hit = 0;
        fin = 0; rdv_pend = 0; prev_stall = 0; prev_req = '0; fcnt = 0; hold = 0;
        for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
            @(negedge clk);
            start    = (cyc == 0) || (busy && $urandom_range(99) < 5);
            src_base = (cyc == 0) ? sb : $urandom();
            dst_base = (cyc == 0) ? db : $urandom();
            bypass   = (cyc == 0) ? byp : 1'($urandom_range(1));
            avm_waitrequest = ($urandom_range(99) < stall_pct);
            abort = 1'b0;
            if (abort_rd >= 0 && avm_read && rd_q.size() == abort_rd && hold < 3) begin
                avm_waitrequest = 1'b1;
                abort = (hold == 0);
                hold++;
            end
            avm_readdatavalid = rdv_pend || (spur_pct > 0 && $urandom_range(99) < spur_pct);
            filt_done = filt_start;
            if (fcnt > 0) begin
                fcnt--;
                if (fcnt == 0) filt_done = 1'b1;
            end
            if (rst_wr >= 0 && avm_write && wr_q.size() >= rst_wr) begin
                n_rst = 1'b0;
                #1;
                rst_vec = {avm_address, avm_read, avm_write, rd_push, wr_pop, filt_start,
                           busy, done, aborted, tile_x, tile_y};
                rst_hit = 1;
                fin = 1;
            end else begin
                #1;
                if (prev_stall && ({avm_read, avm_write, avm_address} !== prev_req)) viol++;
                prev_stall = (avm_read || avm_write) && avm_waitrequest;
                prev_req   = {avm_read, avm_write, avm_address};
                if ($isunknown({avm_address, avm_read, avm_write, rd_push, wr_pop, filt_start,
                                busy, done, aborted, tile_x, tile_y})) xcnt++;
                rdv_next = 0;
                if (avm_read && !avm_waitrequest) begin
                    rd_q.push_back(avm_address);
                    tq.push_back(int'(tile_y) * NTX + int'(tile_x));
                    rdv_next = 1;
                end
                if (avm_write && !avm_waitrequest) begin
                    wr_q.push_back(avm_address);
                    last_wr_cyc = cyc;
                end
                if (rd_push !== rdv_pend) push_mis++;
                if (rd_push === 1'b1) begin n_push++; last_push_cyc = cyc; end
                if (wr_pop !== (avm_write && !avm_waitrequest)) pop_mis++;
                if (wr_pop === 1'b1) n_pop++;
                if (filt_start === 1'b1) begin n_fs++; fcnt = fdelay; end
                if (done === 1'b1) begin
                    n_done++;
                    done_cyc = cyc;
                    ab_at_done = aborted;
                    fin = 1;
                end
                rdv_pend = rdv_next;
            end
        end
        timed_out = !fin;
        if (!rst_hit) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; avm_readdatavalid = 1'b0; filt_done = 1'b0;
            #1;
            busy_after    = busy;
            aborted_after = aborted;
        end
        start = 1'b0; abort = 1'b0; avm_readdatavalid = 1'b0; filt_done = 1'b0;
        avm_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (avm_address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", avm_address); end
        checks++; if ({avm_read, avm_write, filt_start} !== 3'b000) begin errors++; $display("FAIL reset_req: got %b expected 000", {avm_read, avm_write, filt_start}); end
        checks++; if ({rd_push, wr_pop} !== 2'b00) begin errors++; $display("FAIL reset_push_pop: got %b expected 00", {rd_push, wr_pop}); end
        checks++; if ({busy, done, aborted} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {busy, done, aborted}); end
        checks++; if ({tile_x, tile_y} !== 2'b00) begin errors++; $display("FAIL reset_tile: got %b expected 00", {tile_x, tile_y}); end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame_basic();
        logic [31:0] sb, db;
        int          bad, first;
        sb = 32'h1000_0000; db = 32'h2000_0000;
        run_frame(0, 0, 0, -1, -1, 5, sb, db);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got timeout expected done"); end
        checks++; if (rd_q.size() != NPIX) begin errors++; $display("FAIL basic_reads: got %0d expected %0d", rd_q.size(), NPIX); end
        checks++; if (wr_q.size() != NPIX) begin errors++; $display("FAIL basic_writes: got %0d expected %0d", wr_q.size(), NPIX); end
        checks++; if (rd_q.size() > 0 && rd_q[0] !== sb) begin errors++; $display("FAIL basic_first_addr: got %h expected %h", rd_q[0], sb); end
        checks++; if (rd_q.size() > 48 && rd_q[48] !== sb + 32'd32) begin errors++; $display("FAIL basic_tile1_addr: got %h expected %h", rd_q[48], sb + 32'd32); end
        checks++; if (rd_q.size() > 96 && rd_q[96] !== sb + 32'd384) begin errors++; $display("FAIL basic_tile2_addr: got %h expected %h", rd_q[96], sb + 32'd384); end
        bad = 0; first = -1;
        for (int k = 0; k < NPIX; k++)
            if (k >= rd_q.size() || k >= wr_q.size() || k >= tq.size() || rd_q[k] !== model_addr(sb, k)
                || wr_q[k] !== model_addr(db, k) || tq[k] != k / NPX) begin
                bad++;
                if (first < 0) first = k;
            end
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_addr_seq: got %0d bad pixels (first %0d) expected 0", bad, first); end
        checks++; if (n_fs != 4) begin errors++; $display("FAIL basic_filt_start: got %0d expected 4", n_fs); end
        checks++; if (n_done != 1 || ab_at_done) begin errors++; $display("FAIL basic_done: got %0d pulses aborted=%0b expected 1 aborted=0", n_done, ab_at_done); end
        checks++; if (done_cyc != last_wr_cyc + 2) begin errors++; $display("FAIL basic_done_time: got cycle %0d expected %0d", done_cyc, last_wr_cyc + 2); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy_after); end
        checks++; if (n_push != NPIX || n_pop != NPIX || push_mis != 0 || pop_mis != 0) begin errors++; $display("FAIL basic_push_pop: got push=%0d pop=%0d pmis=%0d wmis=%0d expected %0d/%0d/0/0", n_push, n_pop, push_mis, pop_mis, NPIX, NPIX); end
    endtask

    task automatic test_stall();
        logic [31:0] sb, db;
        int          bad;
        sb = $urandom() & 32'h0FFF_FFFC; db = $urandom() & 32'h0FFF_FFFC;
        run_frame(0, 50, 20, -1, -1, $urandom_range(1, 8), sb, db);
        checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout: got timeout expected done"); end
        checks++; if (viol != 0) begin errors++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", viol); end
        checks++; if (n_push != NPIX || n_pop != NPIX) begin errors++; $display("FAIL stall_counts: got push=%0d pop=%0d expected %0d", n_push, n_pop, NPIX); end
        checks++; if (push_mis != 0) begin errors++; $display("FAIL stall_spurious_push: got %0d bad cycles expected 0", push_mis); end
        checks++; if (pop_mis != 0) begin errors++; $display("FAIL stall_pop: got %0d bad cycles expected 0", pop_mis); end
        bad = 0;
        for (int k = 0; k < NPIX; k++)
            if (k >= rd_q.size() || k >= wr_q.size() || rd_q[k] !== model_addr(sb, k) || wr_q[k] !== model_addr(db, k)) bad++;
        checks++; if (bad != 0 || rd_q.size() != NPIX || wr_q.size() != NPIX) begin errors++; $display("FAIL stall_addr_seq: got %0d bad, %0d reads, %0d writes expected 0/%0d/%0d", bad, rd_q.size(), wr_q.size(), NPIX, NPIX); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL stall_done: got %0d expected 1", n_done); end
    endtask

    task automatic test_bypass();
        logic [31:0] sb, db;
        int          bad;
        sb = 32'h0000_4000; db = 32'h8000_0100;
        run_frame(1, 30, 0, -1, -1, 5, sb, db);
        checks++; if (n_fs != 0) begin errors++; $display("FAIL bypass_filt_start: got %0d expected 0", n_fs); end
        bad = 0;
        for (int k = 0; k < NPIX; k++)
            if (k >= rd_q.size() || k >= wr_q.size() || (rd_q[k] - sb) !== (wr_q[k] - db) || rd_q[k] !== model_addr(sb, k)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bypass_seq: got %0d differing pixels expected 0", bad); end
        checks++; if (n_done != 1 || timed_out) begin errors++; $display("FAIL bypass_done: got %0d expected 1", n_done); end
    endtask

    task automatic test_abort();
        run_frame(0, 0, 0, 50, -1, 3, 32'h0001_0000, 32'h0002_0000);
        checks++; if (n_push != 51 || rd_q.size() != 51) begin errors++; $display("FAIL abort_reads: got push=%0d reads=%0d expected 51", n_push, rd_q.size()); end
        checks++; if (wr_q.size() != 48) begin errors++; $display("FAIL abort_writes: got %0d expected 48", wr_q.size()); end
        checks++; if (done_cyc != last_push_cyc + 1) begin errors++; $display("FAIL abort_done_time: got %0d expected %0d", done_cyc, last_push_cyc + 1); end
        checks++; if (n_done != 1 || !ab_at_done) begin errors++; $display("FAIL abort_flag: got done=%0d aborted=%0b expected 1/1", n_done, ab_at_done); end
        checks++; if (busy_after !== 1'b0 || aborted_after !== 1'b1) begin errors++; $display("FAIL abort_after: got busy=%b aborted=%b expected 0/1", busy_after, aborted_after); end
    endtask

    task automatic test_wrap();
        logic [31:0] sb, got4;
        int          bad;
        sb = 32'hFFFF_FFF0;
        run_frame(0, 0, 0, -1, -1, 2, sb, 32'h0000_8000);
        got4 = (rd_q.size() > 4) ? rd_q[4] : 32'hDEAD_BEEF;
        checks++; if (got4 !== 32'h0) begin errors++; $display("FAIL wrap_px4: got %h expected 00000000", got4); end
        checks++; if (xcnt != 0) begin errors++; $display("FAIL wrap_x: got %0d unknown cycles expected 0", xcnt); end
        bad = 0;
        for (int k = 0; k < NPIX; k++)
            if (k >= rd_q.size() || rd_q[k] !== model_addr(sb, k)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_seq: got %0d bad expected 0", bad); end
        checks++; if (ab_at_done !== 1'b0) begin errors++; $display("FAIL wrap_aborted_clear: got %b expected 0", ab_at_done); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] sb;
        run_frame(0, 0, 0, -1, 100, 4, 32'h0300_0000, 32'h0400_0000);
        checks++; if (!rst_hit) begin errors++; $display("FAIL midrst_reached: got no tile-2 write expected one"); end
        checks++; if (rst_vec !== '0) begin errors++; $display("FAIL midrst_outputs: got %h expected 0", rst_vec); end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        sb = 32'h0500_0040;
        run_frame(0, 0, 0, -1, -1, 4, sb, 32'h0600_0000);
        checks++; if (rd_q.size() == 0 || rd_q[0] !== sb || tq[0] != 0) begin errors++; $display("FAIL midrst_restart: got %0d reads expected first at %h tile 0", rd_q.size(), sb); end
        checks++; if (rd_q.size() != NPIX || n_done != 1) begin errors++; $display("FAIL midrst_frame: got reads=%0d done=%0d expected %0d/1", rd_q.size(), n_done, NPIX); end
    endtask

    initial begin
        test_reset();
        test_frame_basic();
        test_stall();
        test_bypass();
        test_abort();
        test_wrap();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tile_stream_ctrl.md
# tile_stream_ctrl

Parametrised tile sequencer for the cartoonifier memory path. It walks an IMG_W x IMG_H image in raster order of TILE_W x TILE_H tiles. For each tile it reads every pixel from source memory over the Avalon-MM master, hands the tile to the filter, then writes the filtered tile to destination memory. It sits between the Avalon master port and the read/write pixel buffers and generalises the fixed 640-wide block controller to arbitrary image and tile geometry, back-pressure, bypass and abort.

## Interface
- IMG_W, 640: image width in pixels; must be a multiple of TILE_W.
- IMG_H, 480: image height in pixels; must be a multiple of TILE_H.
- TILE_W, 8: tile width in pixels.
- TILE_H, 6: tile height in pixels.
- BPP, 4: address step per pixel, in bytes.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a frame; sampled only in IDLE.
- abort  in  1  stop the frame at the next transaction boundary.
- bypass  in  1  skip the filter handshake; sampled at start.
- src_base  in  ADDR_W  source frame byte address; sampled at start.
- dst_base  in  ADDR_W  destination frame byte address; sampled at start.
- avm_address  out  ADDR_W  master address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_waitrequest  in  1  slave stall.
- avm_readdatavalid  in  1  read data valid.
- rd_push  out  1  push avm_readdata into the read buffer.
- wr_pop  out  1  write buffer advances to the next pixel.
- filt_start  out  1  one-cycle pulse: tile is loaded, begin filtering.
- filt_done  in  1  filter finished the current tile.
- tile_x  out  clog2(IMG_W/TILE_W)  current tile column.
- tile_y  out  clog2(IMG_H/TILE_H)  current tile row.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: frame complete or aborted.
- aborted  out  1  with done, frame ended by abort; held until next start.

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, FILT_GO, FILT_WAIT, WR_REQ, NEXT, FIN.
- IDLE: on start, latch base addresses and bypass, clear all counters and aborted, go to RD_REQ.
- RD_REQ: avm_read=1, address = src pixel. If !avm_waitrequest go to RD_WAIT.
- RD_WAIT: wait for avm_readdatavalid; on it, rd_push=1 that cycle and advance the pixel counter.
  - If the pixel was the last in the tile: go to FILT_GO, or straight to WR_REQ when bypass.
  - Otherwise go to RD_REQ.
- Only one read is outstanding at any time.
- FILT_GO: filt_start=1 for one cycle, then FILT_WAIT.
- FILT_WAIT: on filt_done, clear the pixel counter and go to WR_REQ.
- WR_REQ: avm_write=1, address = dst pixel. When !avm_waitrequest, wr_pop=1 that cycle and advance the pixel counter. After the last pixel in the tile go to NEXT.
- NEXT: advance tile_x. On wrap, clear tile_x and advance tile_y. After the last tile go to FIN, otherwise RD_REQ.
- FIN: done=1 for one cycle, then IDLE.
- Pixel order within a tile is row-major: px_x 0..TILE_W-1, then px_y. Tile order is row-major.
- Address = base + ((tile_y*TILE_H + px_y)*IMG_W + tile_x*TILE_W + px_x)*BPP, computed in ADDR_W bits; overflow wraps modulo 2^ADDR_W.
- Abort is latched as a sticky request; it is honoured only at these boundaries:
  - RD_WAIT completion;
  - WR_REQ acceptance;
  - FILT_WAIT on filt_done.
- An honoured abort goes to FIN with aborted=1. A request on the bus is never withdrawn.
- start while busy is ignored.

## Timing
- Reset values:
  - state IDLE;
  - avm_address 0;
  - avm_read, avm_write, rd_push, wr_pop, filt_start, busy, done, aborted all 0;
  - tile_x and tile_y 0.
- avm_address is registered and becomes valid the cycle avm_read or avm_write rises. Address, read and write are held stable while avm_waitrequest=1.
- Bus latency:
  - Read, zero wait states, readdatavalid the following cycle: 2 cycles per pixel.
  - Write, zero wait states: 1 cycle per pixel.
- Per tile with zero wait: 2*TILE_W*TILE_H + 2 + filter time + TILE_W*TILE_H + 1 cycles.
- done asserts in the cycle after the final write acceptance plus one NEXT cycle.
- busy deasserts the cycle after done.
- filt_done arriving in the same cycle as filt_start is ignored; it is sampled only in FILT_WAIT.
- avm_readdatavalid outside RD_WAIT is ignored and produces no rd_push.
- Asynchronous reset mid-frame returns to IDLE immediately. Any bus request drops; the master port is held in reset by the same n_rst.

## Test plan
- IMG 16x12, TILE 8x6, bypass=0, zero wait, filter done 5 cycles after filt_start:
  - 4 tiles, each 48 reads then 48 writes.
  - First read address src_base; tile 1 first address src_base+32; tile 2 first address src_base+16*6*4=src_base+384.
  - Exactly one done pulse.
- Same config, avm_waitrequest random 50%:
  - Address, read and write stable during every stall.
  - rd_push count 192, wr_pop count 192; no duplicate or skipped address.
- bypass=1: filt_start never pulses; read and write address sequences are identical apart from base offset.
- abort pulsed while a read is stalled in tile 1:
  - The read completes with rd_push=1.
  - Next cycle FIN: done=1, aborted=1; then IDLE.
- src_base=0xFFFF_FFF0: address wraps to 0x0000_0000 at pixel 4; no X values.
- n_rst asserted during WR_REQ of tile 2:
  - All outputs are 0 immediately.
  - A subsequent start restarts at tile 0 with address src_base.
